strobe_capture_buffer: RTL and testbench
========================================

// Module: strobe_capture_buffer
// PURPOSE
//  Parametrised successor to the strobe output register bank.
//  Captures STRB_DATA words into a DEPTH-entry register file on each STRB_VALID.
//  Adds arm/clear control, a stop-or-wrap full policy, a sticky overflow flag,
//  a registered random-access read port and a flat parallel image for the test bench.
// PARAMETERS
//  DATA_W    8   width of each captured word
//  DEPTH     32  number of entries; power of two, >=2
//  WRAP_MODE 0   0: stop capturing when full; 1: wrap and overwrite the oldest entry
// PORTS
//  CLK        in   1               clock; all logic on posedge
//  RST_N      in   1               synchronous active-low reset
//  ARM        in   1               1-cycle pulse; starts a capture from IDLE or DONE
//  CLR        in   1               1-cycle pulse; empties the buffer and returns to IDLE
//  STRB_DATA  in   DATA_W          word to capture
//  STRB_VALID in   1               capture qualifier
//  RD_ADDR    in   log2(DEPTH)     read address
//  RD_DATA    out  DATA_W          OUT_REG[RD_ADDR], registered, 1-cycle latency
//  STRB_CNTS  out  log2(DEPTH)+1   words held, saturating at DEPTH
//  WR_PTR     out  log2(DEPTH)     next entry to write
//  FULL       out  1               STRB_CNTS==DEPTH
//  OVERFLOW   out  1               sticky; a strobe was dropped (stop) or overwrote an entry (wrap)
//  BUSY       out  1               state==CAPTURE
//  OUT_FLAT   out  DATA_W*DEPTH    entry i at bits [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (RST_N==0 at posedge)
//   - State goes to IDLE; all entries, RD_DATA, STRB_CNTS, WR_PTR, OVERFLOW, FULL and BUSY are 0.
//   - Reset mid-capture discards everything; no partial state survives.
//  FSM states IDLE, CAPTURE, DONE. Priority per cycle: RST_N > CLR > ARM > STRB_VALID.
//   - IDLE: STRB_VALID is ignored. ARM moves to CAPTURE.
//   - CAPTURE: ARM has no effect.
//     - STRB_VALID && !FULL: OUT_REG[WR_PTR]<=STRB_DATA, WR_PTR+1 (mod DEPTH), STRB_CNTS+1.
//     - Stop mode: the write that makes the count DEPTH moves the FSM to DONE next cycle.
//     - Wrap mode, STRB_VALID && FULL: overwrite OUT_REG[WR_PTR], advance WR_PTR,
//       STRB_CNTS stays at DEPTH, OVERFLOW<=1, stay in CAPTURE.
//   - DONE (stop mode only): STRB_VALID is dropped and sets OVERFLOW<=1.
//     ARM re-arms to CAPTURE and clears STRB_CNTS, WR_PTR and OVERFLOW; entries are kept.
//   - CLR in any state: STRB_CNTS, WR_PTR and OVERFLOW go to 0 and the FSM goes to IDLE.
//     Entries are zeroed. A STRB_VALID in the same cycle is not captured.
//   - ARM with STRB_VALID in the same cycle, from IDLE or DONE: the strobe is not
//     captured; capture starts the next cycle.
//  Write-then-read
//   - A write lands at the posedge.
//   - A read of the same address issued in that cycle returns the old value.
//   - The new value is visible from the next RD_ADDR cycle.
//  FULL, BUSY and OUT_FLAT are decoded from registered state with no extra latency.
//  All counter and pointer arithmetic is unsigned. WR_PTR wraps naturally at DEPTH.
// TESTING
//  T1 reset
//   - Drive RST_N=0 while busy -> every output 0, state IDLE.
//   - Strobes in IDLE -> STRB_CNTS stays 0.
//  T2 stop mode, DEPTH=4
//   - ARM, then 5 strobes of 0x11..0x55 -> entries 0x11..0x44, FULL=1, DONE.
//   - The 5th strobe is dropped and OVERFLOW=1.
//  T3 wrap mode, DEPTH=4
//   - ARM, then 6 strobes of 0x11..0x66 -> entries {0x55,0x66,0x33,0x44}.
//   - WR_PTR=2, STRB_CNTS=4, OVERFLOW=1, BUSY=1.
//  T4 simultaneous events
//   - CLR together with STRB_VALID -> nothing captured, STRB_CNTS=0, IDLE.
//   - ARM together with STRB_VALID -> that strobe is not captured.
//  T5 read port
//   - Write 0xA5 to entry 3, then RD_ADDR=3 -> RD_DATA=0xA5 one cycle later.
//   - OUT_FLAT[31:24]=0xA5.
//   - Same-cycle write/read of entry 3 returns the old data.
//  T6 re-arm from DONE -> counters and OVERFLOW are 0, entries keep their old data
//     until overwritten.

Source files
------------

// File: rtl/strobe_capture_buffer.sv
// Strobe capture buffer: records qualified strobe words into a DEPTH-entry register file
// under arm/clear control, with stop-or-wrap full handling and a sticky overflow flag.
module strobe_capture_buffer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned WRAP_MODE = 0,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       strb_data,
  input  logic                    strb_valid,
  input  logic [AW-1:0]           rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic [AW:0]             strb_cnts,
  output logic [AW-1:0]           wr_ptr,
  output logic                    full,
  output logic                    overflow,
  output logic                    busy,
  output logic [DATA_W*DEPTH-1:0] out_flat
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LAST_CNT = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0]        state_q, state_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic              we;
  logic              wipe;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  assign full      = (cnt_q == FULL_CNT);
  assign busy      = (state_q == ST_CAPTURE);
  assign strb_cnts = cnt_q;
  assign wr_ptr    = ptr_q;
  assign overflow  = ovf_q;
  assign rd_data   = rd_q;

  // Next-state decode; CLR outranks ARM, which outranks a strobe in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wipe    = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ptr_d   = '0;
      ovf_d   = 1'b0;
      wipe    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (strb_valid) begin
            if (!full) begin
              we    = 1'b1;
              ptr_d = ptr_q + PTR_ONE;
              cnt_d = cnt_q + CNT_ONE;
              if (WRAP_MODE == 0 && cnt_q == LAST_CNT) state_d = ST_DONE;
            end else begin
              // Full: wrap overwrites the oldest entry; either way a word was lost.
              ovf_d = 1'b1;
              if (WRAP_MODE != 0) begin
                we    = 1'b1;
                ptr_d = ptr_q + PTR_ONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (arm) begin
            state_d = ST_CAPTURE;
            cnt_d   = '0;
            ptr_d   = '0;
            ovf_d   = 1'b0;
          end else if (strb_valid) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; cleared by reset or CLR, written at the current write pointer.
  always_ff @(posedge clk) begin
    if (!rst_n || wipe) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[ptr_q] <= strb_data;
    end
  end

  // Registered read port; a same-cycle write is not yet visible.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= mem_q[rd_addr];
  end

  // Flat parallel image of all entries.
  always_comb begin
    out_flat = '0;
    for (int i = 0; i < int'(DEPTH); i++) out_flat[i*DATA_W +: DATA_W] = mem_q[i];
  end

endmodule

// File: tb/tb_strobe_capture_buffer.sv
// Bench for strobe_capture_buffer: a stop-mode and a wrap-mode instance (DEPTH=4) share
// stimulus and are compared each cycle against a write-count based reference model.
module tb_strobe_capture_buffer;

  logic       clk = 1'b0;
  logic       rst_n, arm, clr, strb_valid;
  logic [7:0] strb_data;
  logic [1:0] rd_addr;

  logic [7:0]  s_rd, w_rd;
  logic [2:0]  s_cnt, w_cnt;
  logic [1:0]  s_ptr, w_ptr;
  logic        s_full, w_full, s_ovf, w_ovf, s_busy, w_busy;
  logic [31:0] s_flat, w_flat;

  int checks = 0;
  int failures = 0;

  // Model: entries, writes accepted since last arm/clear, overflow, phase (0 idle 1 cap 2 done)
  logic [7:0] m_mem [2][4];
  int         m_n   [2];
  bit         m_ovf [2];
  int         m_st  [2];
  logic [7:0] m_rd  [2];

  always #5 clk = ~clk;

  strobe_capture_buffer #(.DATA_W(8), .DEPTH(4), .WRAP_MODE(0)) u_stop (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clr(clr), .strb_data(strb_data),
    .strb_valid(strb_valid), .rd_addr(rd_addr), .rd_data(s_rd), .strb_cnts(s_cnt),
    .wr_ptr(s_ptr), .full(s_full), .overflow(s_ovf), .busy(s_busy), .out_flat(s_flat)
  );

  strobe_capture_buffer #(.DATA_W(8), .DEPTH(4), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clr(clr), .strb_data(strb_data),
    .strb_valid(strb_valid), .rd_addr(rd_addr), .rd_data(w_rd), .strb_cnts(w_cnt),
    .wr_ptr(w_ptr), .full(w_full), .overflow(w_ovf), .busy(w_busy), .out_flat(w_flat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mstep(input int i, input bit a, input bit c, input bit v,
                                input bit r, input logic [7:0] d, input logic [1:0] ad);
    bit wrap = (i == 1);
    if (!r) begin
      for (int k = 0; k < 4; k++) m_mem[i][k] = 8'h00;
      m_n[i] = 0; m_ovf[i] = 0; m_st[i] = 0; m_rd[i] = 8'h00;
      return;
    end
    m_rd[i] = m_mem[i][ad];
    if (c) begin
      for (int k = 0; k < 4; k++) m_mem[i][k] = 8'h00;
      m_n[i] = 0; m_ovf[i] = 0; m_st[i] = 0;
    end else if (m_st[i] == 0) begin
      if (a) m_st[i] = 1;
    end else if (m_st[i] == 1) begin
      if (v) begin
        if (wrap || m_n[i] < 4) begin
          if (m_n[i] >= 4) m_ovf[i] = 1;
          m_mem[i][m_n[i] % 4] = d;
          m_n[i]++;
          if (!wrap && m_n[i] == 4) m_st[i] = 2;
        end else begin
          m_ovf[i] = 1;
        end
      end
    end else begin
      if (a) begin
        m_st[i] = 1; m_n[i] = 0; m_ovf[i] = 0;
      end else if (v) begin
        m_ovf[i] = 1;
      end
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] ef;
      logic [7:0]  rd;
      logic [2:0]  cnt;
      logic [1:0]  ptr;
      logic        fl, ov, bz;
      logic [31:0] fexp;
      string       p;
      p    = (i == 0) ? "stop" : "wrap";
      fexp = {m_mem[i][3], m_mem[i][2], m_mem[i][1], m_mem[i][0]};
      if (i == 0) begin ef = s_flat; rd = s_rd; cnt = s_cnt; ptr = s_ptr; fl = s_full;
        ov = s_ovf; bz = s_busy; end
      else begin ef = w_flat; rd = w_rd; cnt = w_cnt; ptr = w_ptr; fl = w_full;
        ov = w_ovf; bz = w_busy; end
      chk({p, "_flat"}, ef, fexp);
      chk({p, "_rd"}, 32'(rd), 32'(m_rd[i]));
      chk({p, "_cnt"}, 32'(cnt), (m_n[i] > 4) ? 32'd4 : 32'(m_n[i]));
      chk({p, "_ptr"}, 32'(ptr), 32'(m_n[i] % 4));
      chk({p, "_full"}, 32'(fl), 32'(m_n[i] >= 4));
      chk({p, "_ovf"}, 32'(ov), 32'(m_ovf[i]));
      chk({p, "_busy"}, 32'(bz), 32'(m_st[i] == 1));
    end
  endtask

  task automatic cyc(input bit a, input bit c, input bit v, input logic [7:0] d,
                     input logic [1:0] ad, input bit r);
    arm = a; clr = c; strb_valid = v; strb_data = d; rd_addr = ad; rst_n = r;
    @(posedge clk);
    mstep(0, a, c, v, r, d, ad);
    mstep(1, a, c, v, r, d, ad);
    #1;
    compare_all();
  endtask

  initial begin
    // T1: reset, then strobes while idle are ignored
    cyc(0, 0, 0, 8'h00, 2'd0, 0);
    cyc(0, 0, 0, 8'h00, 2'd0, 0);
    chk("t1_reset_flat", s_flat, 32'h0);
    chk("t1_reset_cnt", 32'(s_cnt), 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 8'hE0 + 8'(k), 2'd0, 1);
    chk("t1_idle_cnt", 32'(s_cnt), 32'd0);

    // T2/T3: arm, then strobes 0x11..0x66
    cyc(1, 0, 0, 8'h00, 2'd0, 1);
    for (int k = 1; k <= 6; k++) cyc(0, 0, 1, 8'(k * 17), 2'd0, 1);
    chk("t2_flat", s_flat, 32'h44332211);
    chk("t2_full", 32'(s_full), 32'd1);
    chk("t2_ovf", 32'(s_ovf), 32'd1);
    chk("t2_busy", 32'(s_busy), 32'd0);
    chk("t3_flat", w_flat, 32'h44336655);
    chk("t3_ptr", 32'(w_ptr), 32'd2);
    chk("t3_cnt", 32'(w_cnt), 32'd4);
    chk("t3_ovf", 32'(w_ovf), 32'd1);
    chk("t3_busy", 32'(w_busy), 32'd1);

    // T4: CLR with strobe, then ARM with strobe
    cyc(0, 1, 1, 8'h99, 2'd0, 1);
    chk("t4_clr_cnt", 32'(s_cnt), 32'd0);
    chk("t4_clr_busy", 32'(w_busy), 32'd0);
    cyc(1, 0, 1, 8'h99, 2'd0, 1);
    chk("t4_arm_cnt", 32'(s_cnt), 32'd0);
    chk("t4_arm_busy", 32'(s_busy), 32'd1);

    // T5: write 0xA5 to entry 3 while reading it, then read again
    for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 8'(k), 2'd0, 1);
    cyc(0, 0, 1, 8'hA5, 2'd3, 1);
    chk("t5_same_cycle_rd", 32'(s_rd), 32'h00);
    chk("t5_flat_hi", 32'(s_flat[31:24]), 32'hA5);
    cyc(0, 0, 0, 8'h00, 2'd3, 1);
    chk("t5_rd", 32'(s_rd), 32'hA5);

    // T6: re-arm stop instance from DONE; entries persist until overwritten
    cyc(1, 0, 0, 8'h00, 2'd0, 1);
    chk("t6_cnt", 32'(s_cnt), 32'd0);
    chk("t6_ovf", 32'(s_ovf), 32'd0);
    chk("t6_flat", s_flat, 32'hA5030201);
    cyc(0, 0, 1, 8'h77, 2'd0, 1);
    chk("t6_overwrite", s_flat, 32'hA5030277);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      int unsigned p;
      p = $urandom_range(0, 99);
      cyc(p >= 90 && p < 98, p >= 98, $urandom_range(0, 1) == 1, 8'($urandom),
          2'($urandom_range(0, 3)), $urandom_range(0, 99) != 0);
    end

    // Reset mid-capture
    cyc(1, 0, 0, 8'h00, 2'd0, 1);
    cyc(0, 0, 1, 8'h5A, 2'd0, 1);
    cyc(0, 0, 1, 8'h5B, 2'd1, 0);
    chk("t1_midrst_flat", w_flat, 32'h0);
    chk("t1_midrst_busy", 32'(w_busy), 32'd0);
    chk("t1_midrst_cnt", 32'(w_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
